// File: rtl/delay_pkg.sv
// Shared defaults for the delay line and its stage register.
package delay_pkg;

  localparam int DELAY_DEFAULT_WIDTH  = 1;
  localparam int DELAY_DEFAULT_CYCLES = 1;

endpackage : delay_pkg

// File: rtl/delay_stage.sv
// Single WIDTH-bit register with synchronous reset to RESET_VALUE.
// Latency 1 cycle; no backpressure, captures every clock.
module delay_stage
  import delay_pkg::*;
#(
  parameter int               WIDTH       = DELAY_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d_i;
    if (reset) q_d = RESET_VALUE;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : delay_stage

// File: rtl/delay.sv
// Synchronous delay line: dout is din delayed by CYCLES clocks (CYCLES=0 is a wire).
// No enable and no backpressure; the chain advances on every clock.
module delay
  import delay_pkg::*;
#(
  parameter int               WIDTH       = DELAY_DEFAULT_WIDTH,
  parameter int               CYCLES      = DELAY_DEFAULT_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "delay: WIDTH must be at least 1");
  end

  if (CYCLES < 0) begin : g_bad_cycles
    $fatal(1, "delay: CYCLES must be 0 or more");
  end

  if (CYCLES == 0) begin : g_passthru
    // Clock and reset are intentionally unused in the passthrough case.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign dout = din;
  end else begin : g_chain
    // chain[0] is the input; chain[k+1] is the output of stage k.
    logic [WIDTH-1:0] chain [CYCLES+1];

    assign chain[0] = din;

    for (genvar k = 0; k < CYCLES; k++) begin : g_stage
      delay_stage #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
      ) u_stage (
        .clk  (clk),
        .reset(reset),
        .d_i  (chain[k]),
        .q_o  (chain[k+1])
      );
    end

    assign dout = chain[CYCLES];
  end

endmodule : delay

// File: tb/tb_delay.sv
// Directed and scoreboarded checks of delay across several parameter sets.
module tb_delay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default 1-bit, 1-cycle instance.
  logic r0, d0, q0;
  delay u0 (.clk(clk), .reset(r0), .din(d0), .dout(q0));

  // 8-bit, 3-cycle instances sharing a ramp input.
  logic       r1, r2;
  logic [7:0] d8, q1, q2;
  delay #(.WIDTH(8), .CYCLES(3)) u1 (.clk(clk), .reset(r1), .din(d8), .dout(q1));
  delay #(.WIDTH(8), .CYCLES(3), .RESET_VALUE(8'hA5)) u2 (.clk(clk), .reset(r2), .din(d8), .dout(q2));

  // Zero-cycle passthrough.
  logic       r3;
  logic [3:0] d4, q3;
  delay #(.WIDTH(4), .CYCLES(0)) u3 (.clk(clk), .reset(r3), .din(d4), .dout(q3));

  // Randomly driven instances checked against a history-based model.
  logic        rr;
  logic [31:0] dr, q5;
  logic [12:0] q4;
  delay #(.WIDTH(13), .CYCLES(5), .RESET_VALUE(13'h0ABC)) u4 (.clk(clk), .reset(rr), .din(dr[12:0]), .dout(q4));
  delay #(.WIDTH(32), .CYCLES(16), .RESET_VALUE(32'hDEADBEEF)) u5 (.clk(clk), .reset(rr), .din(dr), .dout(q5));

  localparam int NRAND = 300;
  logic [31:0] din_h [NRAND];
  logic        rst_h [NRAND];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output seen after edge c: reset value if any reset edge lies in the last
  // cyc edges, otherwise the input presented cyc edges back.
  function automatic logic [31:0] exp_out(int c, int cyc, logic [31:0] rv);
    int lo = c + 1 - cyc;
    for (int e = (lo < 0) ? 0 : lo; e <= c; e++)
      if (rst_h[e]) return rv;
    return din_h[lo];
  endfunction

  initial begin
    r0 = 1'b1; d0 = 1'b0;
    r1 = 1'b1; r2 = 1'b1; d8 = 8'h00;
    r3 = 1'b0; d4 = 4'h0;
    rr = 1'b1; dr = '0;

    // Default params: reset, then a rising input after edge 5.
    step();
    check("def_rst", {31'd0, q0}, 32'd0);
    r0 = 1'b0;
    for (int i = 2; i <= 5; i++) step();
    check("def_low_e5", {31'd0, q0}, 32'd0);
    d0 = 1'b1;
    check("def_edge_hi", {31'd0, d0 & ~q0}, 32'd1);
    step();
    check("def_e6", {31'd0, q0}, 32'd1);
    check("def_edge_lo", {31'd0, d0 & ~q0}, 32'd0);

    // Input held high through reset yields one apparent edge.
    r0 = 1'b1;
    step();
    check("hold_rst1", {31'd0, q0}, 32'd0);
    step();
    check("hold_rst2", {31'd0, q0}, 32'd0);
    r0 = 1'b0;
    check("hold_edge_hi", {31'd0, d0 & ~q0}, 32'd1);
    step();
    check("hold_post", {31'd0, q0}, 32'd1);
    check("hold_edge_lo", {31'd0, d0 & ~q0}, 32'd0);

    // Ramp through 8-bit wrap on the 3-cycle lines (reset edge already taken).
    check("ramp_rst0", {24'd0, q1}, 32'h00);
    check("ramp_rstA5", {24'd0, q2}, 32'hA5);
    r1 = 1'b0; r2 = 1'b0;
    for (int i = 0; i < 262; i++) begin
      logic [7:0] v;
      v = i[7:0];
      d8 = v;
      step();
      check("ramp", {24'd0, q1}, (i >= 2) ? 32'((i - 2) & 8'hFF) : 32'h00);
    end

    // Mid-stream reset on the 0xA5 line discards data in flight.
    d8 = 8'h40; step();
    d8 = 8'h41; step();
    d8 = 8'h42; step();
    check("mid_pre", {24'd0, q2}, 32'h40);
    r2 = 1'b1; d8 = 8'h43; step();
    check("mid_rst1", {24'd0, q2}, 32'hA5);
    d8 = 8'h44; step();
    check("mid_rst2", {24'd0, q2}, 32'hA5);
    r2 = 1'b0; d8 = 8'h45; step();
    check("mid_post1", {24'd0, q2}, 32'hA5);
    d8 = 8'h46; step();
    check("mid_post2", {24'd0, q2}, 32'hA5);
    d8 = 8'h47; step();
    check("mid_first", {24'd0, q2}, 32'h45);
    d8 = 8'h48; step();
    check("mid_second", {24'd0, q2}, 32'h46);

    // Zero-cycle passthrough ignores reset.
    d4 = 4'h3; #1;
    check("pass_3", {28'd0, q3}, 32'h3);
    r3 = 1'b1; d4 = 4'hC; #1;
    check("pass_C_rst", {28'd0, q3}, 32'hC);
    step();
    check("pass_C_edge", {28'd0, q3}, 32'hC);

    // Random input and reset against the history model.
    for (int c = 0; c < NRAND; c++) begin
      rr = (c == 0) ? 1'b1 : ($urandom_range(0, 19) == 0);
      dr = $urandom;
      r3 = rr;
      d4 = dr[3:0];
      din_h[c] = dr;
      rst_h[c] = rr;
      step();
      begin
        logic [31:0] e4;
        e4 = exp_out(c, 5, 32'h0000_0ABC);
        check("rand_w13c5", {19'd0, q4}, {19'd0, e4[12:0]});
      end
      check("rand_w32c16", q5, exp_out(c, 16, 32'hDEADBEEF));
      check("rand_w4c0", {28'd0, q3}, {28'd0, dr[3:0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_delay
